// File: rtl/toom8_pkg.sv
// toom8_pkg
//   Shared constants and types for the Toom-8 streaming loader.
//   OP_W / WORD_W       : operand width and stream word width
//   WORDS_PER_OP        : stream words per operand
//   PROD_WORDS          : stream words per product (product is 2*OP_W bits)
//   loader_state_t      : loader FSM states
// Configuration macro used by the loader: TOOM8_FRAME_CHECK_EN.
package toom8_pkg;

    localparam int OP_W         = 1024;
    localparam int WORD_W       = 64;
    localparam int WORDS_PER_OP = OP_W / WORD_W;
    localparam int PROD_WORDS   = 2 * OP_W / WORD_W;

    typedef enum logic [1:0] {
        LOAD_X = 2'd0,
        LOAD_Y = 2'd1,
        WAIT   = 2'd2,
        DRAIN  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/toom8_word_serializer.sv
// toom8_word_serializer
//   Captures a wide product on a load strobe and emits it as a stream of
//   words, least-significant word first.
//   Handshake: a word transfers on a rising clk edge where out_valid and
//   out_ready are both high. Once out_valid rises it stays high, with
//   out_data/out_last stable, until that word has transferred.
// Ports
//   clk, reset_n : clock, synchronous active-low reset
//   load         : one-cycle strobe, captures product and starts a burst
//   product      : SER_PROD_W-bit value to serialise
//   out_valid    : word on out_data is valid
//   out_ready    : downstream accepts the word
//   out_data     : current word (low word of the shift register)
//   out_last     : high with the final word of the burst
//   done         : combinational pulse on the final word's handshake
module toom8_word_serializer
    import toom8_pkg::*;
#(
    parameter int SER_WORD_W = WORD_W,
    parameter int SER_PROD_W = 2 * OP_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [SER_PROD_W-1:0] product,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SER_WORD_W-1:0] out_data,
    output logic                  out_last,
    output logic                  done
);

    localparam int N_WORDS = SER_PROD_W / SER_WORD_W;
    localparam int CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

    logic [SER_PROD_W-1:0] sreg;
    logic [CNT_W-1:0]      ocnt;
    logic                  fire;

    assign fire     = out_valid & out_ready;
    assign done     = fire && (ocnt == CNT_W'(N_WORDS - 1));
    assign out_data = sreg[SER_WORD_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sreg      <= '0;
            ocnt      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            sreg      <= product;
            ocnt      <= '0;
            out_valid <= 1'b1;
            out_last  <= (N_WORDS == 1);
        end else if (fire) begin
            sreg <= sreg >> SER_WORD_W;
            if (done) begin
                ocnt      <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                ocnt     <= ocnt + 1'b1;
                // The word about to be presented is the last one.
                out_last <= (ocnt == CNT_W'(N_WORDS - 2));
            end
        end
    end

endmodule

// File: rtl/toom8_stream_loader.sv
// toom8_stream_loader
//   Streaming front/back end for the 1024x1024 Toom-8 multiplier core.
//   Deserialises 32 input words (X words 0..15 then Y words 0..15, LS word
//   first) into the core operand registers, waits MUL_LAT cycles for the
//   core, then serialises the 2*OP_W-bit product as PROD_WORDS words.
//   One multiplication in flight; input and output never overlap.
//   Handshake (both sides): a word transfers on a rising clk edge where
//   valid and ready are both high; valid holds with stable data until then.
// Configuration
//   TOOM8_FRAME_CHECK_EN defined : in_last checked on every accepted word;
//     premature in_last aborts the job and sets sticky frame_err, missing
//     in_last on Y word 15 only sets frame_err.
//   undefined : in_last ignored, frame_err tied 0.
// Ports
//   clk, reset_n           : clock, synchronous active-low reset
//   in_valid/in_ready      : input word handshake
//   in_data, in_last       : input word, framing marker on the 32nd word
//   mul_x, mul_y           : operands to the core, held stable through WAIT/DRAIN
//   mul_product            : product from the core
//   out_valid/out_ready    : output word handshake
//   out_data, out_last     : output word, marker on product word 31
//   busy                   : low only in LOAD_X with no word received
//   frame_err              : sticky framing error
//   fsm_state              : current loader state (debug visibility)
module toom8_stream_loader #(
    parameter int WORD_W  = toom8_pkg::WORD_W,
    parameter int OP_W    = toom8_pkg::OP_W,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [OP_W-1:0]          mul_x,
    output logic [OP_W-1:0]          mul_y,
    input  logic [2*OP_W-1:0]        mul_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     frame_err,
    output toom8_pkg::loader_state_t fsm_state
);

    import toom8_pkg::*;

    localparam int OP_WORDS  = OP_W / WORD_W;
    localparam int WCNT_W    = (OP_WORDS > 1) ? $clog2(OP_WORDS) : 1;
    localparam int LCNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(OP_WORDS - 1);
    localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(MUL_LAT - 1);

    loader_state_t     state;
    logic [WCNT_W-1:0] wcnt;
    logic [LCNT_W-1:0] lcnt;
    logic              load;
    logic              done;
    logic              accept;
    logic              final_word;
    logic              abort;

    assign accept     = in_valid & in_ready;
    assign final_word = (state == LOAD_Y) && (wcnt == WCNT_LAST);
    assign busy       = !((state == LOAD_X) && (wcnt == '0));
    assign fsm_state  = state;

`ifdef TOOM8_FRAME_CHECK_EN
    logic missing_last;

    assign abort        = accept && in_last && !final_word;
    assign missing_last = accept && !in_last && final_word;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
        end else if (abort || missing_last) begin
            frame_err <= 1'b1;
        end
    end
`else
    logic unused_in_last;

    assign unused_in_last = in_last;
    assign abort          = 1'b0;
    assign frame_err      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= LOAD_X;
            wcnt     <= '0;
            lcnt     <= '0;
            in_ready <= 1'b0;
            mul_x    <= '0;
            mul_y    <= '0;
            load     <= 1'b0;
        end else begin
            load <= 1'b0;
            case (state)
                LOAD_X, LOAD_Y: begin
                    in_ready <= 1'b1;
                    if (abort) begin
                        // Premature in_last: drop the partial job, restart at X word 0.
                        wcnt  <= '0;
                        state <= LOAD_X;
                    end else if (accept) begin
                        if (state == LOAD_X) begin
                            mul_x[wcnt*WORD_W +: WORD_W] <= in_data;
                        end else begin
                            mul_y[wcnt*WORD_W +: WORD_W] <= in_data;
                        end
                        if (wcnt == WCNT_LAST) begin
                            wcnt <= '0;
                            if (state == LOAD_X) begin
                                state <= LOAD_Y;
                            end else begin
                                state    <= WAIT;
                                lcnt     <= '0;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    lcnt <= lcnt + 1'b1;
                    // The load strobe is registered, so the serializer samples
                    // mul_product one cycle after this, MUL_LAT+1 cycles after
                    // the final operand word landed.
                    if (lcnt == LCNT_LAST) begin
                        load  <= 1'b1;
                        lcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state    <= LOAD_X;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD_X;
                end
            endcase
        end
    end

    toom8_word_serializer #(
        .SER_WORD_W(WORD_W),
        .SER_PROD_W(2 * OP_W)
    ) u_serializer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .product  (mul_product),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .done     (done)
    );

endmodule

// File: tb/tb_toom8_stream_loader.sv
// tb_toom8_stream_loader
//   Bench for toom8_stream_loader. The core is modelled as a MUL_LAT-deep
//   pipelined multiplier; expected product words come from X*Y computed
//   directly and are queued when a job's final word is accepted. A monitor
//   compares every presented output word against the queue head.
module tb_toom8_stream_loader;

    import toom8_pkg::*;

    localparam int MUL_LAT  = 2;
    localparam int JOB_WORDS = 2 * WORDS_PER_OP;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_data;
    logic                  in_last;
    logic [OP_W-1:0]       mul_x;
    logic [OP_W-1:0]       mul_y;
    logic [2*OP_W-1:0]     mul_product;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_data;
    logic                  out_last;
    logic                  busy;
    logic                  frame_err;
    loader_state_t         fsm_state;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    toom8_stream_loader #(
        .WORD_W (WORD_W),
        .OP_W   (OP_W),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_product(mul_product),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_err  (frame_err),
        .fsm_state  (fsm_state)
    );

    // ---------------- core model: product valid MUL_LAT cycles after operands ----------------
    logic [2*OP_W-1:0] core_p1;
    logic [2*OP_W-1:0] core_p2;

    always @(posedge clk) begin
        core_p1 <= {{OP_W{1'b0}}, mul_x} * {{OP_W{1'b0}}, mul_y};
        core_p2 <= core_p1;
    end
    assign mul_product = core_p2;

    // ---------------- scoreboard ----------------
    logic [WORD_W:0]  exp_q[$];   // {last, data}
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [OP_W-1:0]  cur_x = '0;
    logic [OP_W-1:0]  cur_y = '0;
    bit               ready_rand = 1'b0;

    task automatic check(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got low word %h required low word %h (full values differ)",
                     name, act[WORD_W-1:0], exp[WORD_W-1:0]);
        end
    endtask

    // Reference: the product is X*Y, emitted LS word first.
    task automatic push_expected(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y);
        logic [2*OP_W-1:0] p;
        p = {{OP_W{1'b0}}, x} * {{OP_W{1'b0}}, y};
        for (int i = 0; i < PROD_WORDS; i++) begin
            exp_q.push_back({(i == PROD_WORDS - 1), p[i*WORD_W +: WORD_W]});
        end
        cur_x = x;
        cur_y = y;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out: got word %h, required no output", out_data);
            end else begin
                check("out_data", out_data, exp_q[0][WORD_W-1:0]);
                check("out_last", WORD_W'(out_last), WORD_W'(exp_q[0][WORD_W]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
        if (reset_n && (fsm_state == WAIT || fsm_state == DRAIN)) begin
            check("in_ready_closed", WORD_W'(in_ready), '0);
            check_wide("mul_x_hold", mul_x, cur_x);
            check_wide("mul_y_hold", mul_y, cur_y);
        end
    end

    // ---------------- downstream ready driver ----------------
    always @(posedge clk) begin
        #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [WORD_W-1:0] d, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 1000) begin
                n_checks++;
                n_fail++;
                $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", n);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    function automatic logic [WORD_W-1:0] job_word(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y, input int i);
        if (i < WORDS_PER_OP) return x[i*WORD_W +: WORD_W];
        return y[(i - WORDS_PER_OP)*WORD_W +: WORD_W];
    endfunction

    task automatic send_job(input logic [OP_W-1:0] x, input logic [OP_W-1:0] y,
                            input int max_gap, input bit check_lat);
        for (int i = 0; i < JOB_WORDS; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_word(job_word(x, y, i), (i == JOB_WORDS - 1));
        end
        push_expected(x, y);
        if (check_lat) begin
            // out_valid must first be seen MUL_LAT+1 cycles after the final handshake.
            for (int k = 1; k <= MUL_LAT + 2; k++) begin
                @(negedge clk);
                check("latency_out_valid", WORD_W'(out_valid), WORD_W'(k == MUL_LAT + 2));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", WORD_W'(exp_q.size()), '0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        logic [OP_W-1:0] r;
        for (int i = 0; i < OP_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  WORD_W'(in_ready),  '0);
        check({tag, "_out_valid"}, WORD_W'(out_valid), '0);
        check({tag, "_out_last"},  WORD_W'(out_last),  '0);
        check({tag, "_busy"},      WORD_W'(busy),      '0);
        check({tag, "_frame_err"}, WORD_W'(frame_err), '0);
        check({tag, "_out_data"},  out_data,           '0);
        check({tag, "_state"},     WORD_W'(fsm_state), WORD_W'(LOAD_X));
        check_wide({tag, "_mul_x"}, mul_x, '0);
        check_wide({tag, "_mul_y"}, mul_y, '0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got simulation still running, required completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [OP_W-1:0] ones;
        logic [OP_W-1:0] rx;
        ones = '1;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        idle(3);
        check_reset_values("reset");
        reset_n = 1'b1;
        idle(1);
        check("in_ready_after_reset", WORD_W'(in_ready), WORD_W'(1));
        out_ready = 1'b1;

        // X=1, Y=1 with latency check
        send_job(OP_W'(1), OP_W'(1), 0, 1'b1);
        check("busy_in_job", WORD_W'(busy), WORD_W'(1));
        wait_drain();

        // X=Y=all ones
        send_job(ones, ones, 0, 1'b1);
        wait_drain();

        // random operands, random input gaps, toggling out_ready
        ready_rand = 1'b1;
        for (int j = 0; j < 4; j++) send_job(rand_op(), rand_op(), 2, 1'b0);
        wait_drain();

        // back-to-back jobs
        send_job(rand_op(), rand_op(), 0, 1'b0);
        send_job(rand_op(), rand_op(), 0, 1'b0);
        send_job(ones, OP_W'(7), 0, 1'b0);
        wait_drain();
        ready_rand = 1'b0;
        idle(1);
        out_ready = 1'b1;

        // mid-job reset after X word 9
        rx = rand_op();
        for (int i = 0; i < 10; i++) send_word(rx[i*WORD_W +: WORD_W], 1'b0);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check_reset_values("midreset");
        idle(1);
        send_job(OP_W'(3), OP_W'(5), 0, 1'b1);
        wait_drain();

        // in_last on X word 5
        rx = rand_op();
        for (int i = 0; i < 6; i++) send_word(rx[i*WORD_W +: WORD_W], (i == 5));
        @(negedge clk);
`ifdef TOOM8_FRAME_CHECK_EN
        check("frame_err_set", WORD_W'(frame_err), WORD_W'(1));
        check("frame_abort_state", WORD_W'(fsm_state), WORD_W'(LOAD_X));
        check("frame_abort_busy", WORD_W'(busy), '0);
        idle(10);
        send_job(OP_W'(9), OP_W'(11), 0, 1'b0);
        wait_drain();
        check("frame_err_sticky", WORD_W'(frame_err), WORD_W'(1));
`else
        check("frame_err_tied", WORD_W'(frame_err), '0);
        check("frame_busy", WORD_W'(busy), WORD_W'(1));
        @(posedge clk);
        #1;
        begin
            logic [OP_W-1:0] ry;
            ry = rand_op();
            for (int i = 6; i < JOB_WORDS; i++) send_word(job_word(rx, ry, i), (i == JOB_WORDS - 1));
            push_expected(rx, ry);
        end
        wait_drain();
        check("frame_err_tied_end", WORD_W'(frame_err), '0);
`endif

        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
